// File: rtl/systolic_nxn.sv
// Weight-stationary N x N systolic array computing out[c] = sum_r in[r] * Wact[r][c].
// Rows of the input vector are skewed into the grid, partial sums flow down the columns,
// and column outputs are deskewed so the whole result vector leaves in one cycle, 2N edges
// after the vector is accepted. A shadow weight bank is filled row by row while the array
// computes and is copied into the active bank once the pipeline has drained.
module systolic_nxn #(
  parameter int unsigned N      = 4,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned PSUM_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N*DATA_W-1:0]      in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N*DATA_W-1:0]      w_data,
  input  logic                     w_valid,
  output logic                     w_ready,
  input  logic                     sw_req,
  output logic                     sw_ack,
  input  logic [$clog2(N+1)-1:0]   col_size,
  input  logic                     col_size_valid,
  output logic [N*PSUM_W-1:0]      out_data,
  output logic                     out_valid
);

  localparam int unsigned Lat   = 2 * N;
  localparam int unsigned CntW  = $clog2(Lat + 2);
  localparam int unsigned KW    = $clog2(N);
  localparam int unsigned ProdW = 2 * DATA_W;

  typedef enum logic [1:0] {StEmpty, StLoading, StFull} sw_state_e;

  // Signed multiply-accumulate; the full product is sign-extended (or truncated) to PSUM_W
  // and the sum wraps.
  function automatic logic signed [PSUM_W-1:0] mac(input logic signed [PSUM_W-1:0] acc,
                                                   input logic signed [DATA_W-1:0] a,
                                                   input logic signed [DATA_W-1:0] b);
    logic signed [ProdW-1:0] p;
    p = a * b;
    return acc + PSUM_W'(p);
  endfunction

  sw_state_e                state_q;
  logic [KW-1:0]            k_q;
  logic                     sw_ack_q;
  logic [CntW-1:0]          inflight_q;
  logic [Lat-1:0]           vld_q;
  logic                     out_valid_q;
  logic [N*PSUM_W-1:0]      out_q;
  logic [N-1:0]             mask_q, mask_d;
  logic                     in_fire, w_fire, emit, do_switch;

  logic signed [DATA_W-1:0] wsh_q  [N][N];
  logic signed [DATA_W-1:0] wact_q [N][N];
  logic signed [DATA_W-1:0] in_q   [N];
  logic signed [DATA_W-1:0] row_x  [N];
  logic signed [DATA_W-1:0] x_q    [N][N-1];
  logic signed [DATA_W-1:0] pe_x   [N][N];
  logic signed [PSUM_W-1:0] ps_q   [N][N];
  logic signed [PSUM_W-1:0] pe_sum [N][N];
  logic signed [PSUM_W-1:0] col_out [N];

  // Inputs stall only while a full shadow bank waits to be switched in.
  assign in_ready  = !((state_q == StFull) && sw_req);
  assign w_ready   = (state_q != StFull);
  assign in_fire   = in_valid && in_ready;
  assign w_fire    = w_valid && w_ready;
  assign emit      = vld_q[Lat-1];
  assign do_switch = (state_q == StFull) && sw_req && (inflight_q == '0);

  assign sw_ack    = sw_ack_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_q;

  // Shadow-weight loader and active-bank switch.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StEmpty;
      k_q      <= '0;
      sw_ack_q <= 1'b0;
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          wsh_q[r][c]  <= '0;
          wact_q[r][c] <= '0;
        end
      end
    end else begin
      sw_ack_q <= 1'b0;
      unique case (state_q)
        StEmpty, StLoading: begin
          if (w_fire) begin
            for (int c = 0; c < N; c++) wsh_q[k_q][c] <= w_data[c*DATA_W +: DATA_W];
            if (k_q == KW'(N - 1)) begin
              k_q     <= '0;
              state_q <= StFull;
            end else begin
              k_q     <= k_q + KW'(1);
              state_q <= StLoading;
            end
          end
        end
        StFull: begin
          if (do_switch) begin
            for (int r = 0; r < N; r++) begin
              for (int c = 0; c < N; c++) wact_q[r][c] <= wsh_q[r][c];
            end
            sw_ack_q <= 1'b1;
            state_q  <= StEmpty;
          end
        end
        default: state_q <= StEmpty;
      endcase
    end
  end

  // Count vectors accepted but not yet emitted; the switch waits for this to reach zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      inflight_q <= '0;
    end else if (in_fire && !emit) begin
      inflight_q <= inflight_q + CntW'(1);
    end else if (!in_fire && emit) begin
      inflight_q <= inflight_q - CntW'(1);
    end
  end

  // Next column-enable mask: the lowest min(col_size, N) columns.
  always_comb begin
    mask_d = mask_q;
    if (col_size_valid) begin
      for (int c = 0; c < N; c++) mask_d[c] = (c < int'(col_size));
    end
  end

  // Input capture (idle cycles inject zeros) and the PE grid registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int r = 0; r < N; r++) begin
        in_q[r] <= '0;
        for (int c = 0; c < N; c++) ps_q[r][c] <= '0;
        for (int c = 0; c < N - 1; c++) x_q[r][c] <= '0;
      end
    end else begin
      for (int r = 0; r < N; r++) begin
        in_q[r] <= in_fire ? in_data[r*DATA_W +: DATA_W] : '0;
        for (int c = 0; c < N; c++) ps_q[r][c] <= pe_sum[r][c];
        for (int c = 0; c < N - 1; c++) x_q[r][c] <= pe_x[r][c];
      end
    end
  end

  // Row r reaches column 0 r cycles late so it meets the partial sum from row r-1.
  for (genvar r = 0; r < N; r++) begin : g_skew
    if (r == 0) begin : g_direct
      assign row_x[r] = in_q[r];
    end else begin : g_delay
      logic signed [DATA_W-1:0] sk_q [r];
      // Skew shift chain for this row.
      always_ff @(posedge clk) begin
        if (!rst) begin
          for (int i = 0; i < r; i++) sk_q[i] <= '0;
        end else begin
          sk_q[0] <= in_q[r];
          for (int i = 1; i < r; i++) sk_q[i] <= sk_q[i-1];
        end
      end
      assign row_x[r] = sk_q[r-1];
    end
  end

  // PE wiring: x moves right along a row, partial sums move down a column.
  for (genvar r = 0; r < N; r++) begin : g_pe_row
    for (genvar c = 0; c < N; c++) begin : g_pe_col
      if (c == 0) begin : g_x_edge
        assign pe_x[r][c] = row_x[r];
      end else begin : g_x_int
        assign pe_x[r][c] = x_q[r][c-1];
      end
      if (r == 0) begin : g_p_edge
        assign pe_sum[r][c] = mac('0, pe_x[r][c], wact_q[r][c]);
      end else begin : g_p_int
        assign pe_sum[r][c] = mac(ps_q[r-1][c], pe_x[r][c], wact_q[r][c]);
      end
    end
  end

  // Column c finishes c cycles after column 0; delay it N-1-c cycles to align all columns.
  for (genvar c = 0; c < N; c++) begin : g_deskew
    localparam int unsigned D = N - 1 - c;
    if (D == 0) begin : g_direct
      assign col_out[c] = ps_q[N-1][c];
    end else begin : g_delay
      logic signed [PSUM_W-1:0] dk_q [D];
      // Deskew shift chain for this column.
      always_ff @(posedge clk) begin
        if (!rst) begin
          for (int i = 0; i < D; i++) dk_q[i] <= '0;
        end else begin
          dk_q[0] <= ps_q[N-1][c];
          for (int i = 1; i < D; i++) dk_q[i] <= dk_q[i-1];
        end
      end
      assign col_out[c] = dk_q[D-1];
    end
  end

  // Valid pipeline, column mask and the masked output register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_q       <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      mask_q      <= '0;
    end else begin
      vld_q       <= {vld_q[Lat-2:0], in_fire};
      out_valid_q <= emit;
      mask_q      <= mask_d;
      for (int c = 0; c < N; c++) begin
        out_q[c*PSUM_W +: PSUM_W] <= mask_q[c] ? col_out[c] : '0;
      end
    end
  end

endmodule

// File: tb/tb_systolic_nxn.sv
// Directed bench for systolic_nxn with N=2, DATA_W=16, PSUM_W=16.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_systolic_nxn;
  localparam int unsigned N   = 2;
  localparam int unsigned DW  = 16;
  localparam int unsigned PW  = 16;
  localparam int unsigned CSW = $clog2(N + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic [N*DW-1:0]   in_data, w_data;
  logic              in_valid, in_ready, w_valid, w_ready, sw_req, sw_ack;
  logic [CSW-1:0]    col_size;
  logic              col_size_valid;
  logic [N*PW-1:0]   out_data;
  logic              out_valid;
  int                checks = 0;
  int                failures = 0;

  always #5 clk = ~clk;

  systolic_nxn #(.N(N), .DATA_W(DW), .PSUM_W(PW)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready),
    .sw_req(sw_req), .sw_ack(sw_ack),
    .col_size(col_size), .col_size_valid(col_size_valid),
    .out_data(out_data), .out_valid(out_valid)
  );

  function automatic logic [N*DW-1:0] vec(input logic [DW-1:0] e0, input logic [DW-1:0] e1);
    return {e1, e0};
  endfunction

  function automatic logic [N*PW-1:0] res(input logic [PW-1:0] r0, input logic [PW-1:0] r1);
    return {r1, r0};
  endfunction

  // All driver tasks start and end on a falling edge.
  task automatic write_row(input logic [N*DW-1:0] row);
    w_data = row; w_valid = 1'b1;
    @(negedge clk);
    w_valid = 1'b0;
  endtask

  task automatic set_cols(input logic [CSW-1:0] v);
    col_size = v; col_size_valid = 1'b1;
    @(negedge clk);
    col_size_valid = 1'b0;
  endtask

  task automatic switch_weights(output logic acked, output int waited);
    sw_req = 1'b1;
    @(negedge clk);
    waited = 0;
    while (!sw_ack && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    acked  = sw_ack;
    sw_req = 1'b0;
  endtask

  task automatic send_vec(input logic [N*DW-1:0] v, output logic [N*PW-1:0] got, output int lat);
    in_data = v; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    got = out_data;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; w_valid = 1'b0; sw_req = 1'b0; col_size_valid = 1'b0;
    in_data = '0; w_data = '0; col_size = '0;
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== '0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    checks++; if (sw_ack !== 1'b0) begin failures++; $display("FAIL reset_sw_ack got=%b exp=0", sw_ack); end
    checks++; if (w_ready !== 1'b1) begin failures++; $display("FAIL reset_w_ready got=%b exp=1", w_ready); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [N*PW-1:0] got;
    int lat, waited;
    logic acked, ack_seen, rdy_low;
    // A switch request with nothing loaded is ignored and does not stall inputs.
    sw_req = 1'b1; ack_seen = 1'b0; rdy_low = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (sw_ack) ack_seen = 1'b1;
      if (!in_ready) rdy_low = 1'b1;
    end
    sw_req = 1'b0;
    checks++; if (ack_seen !== 1'b0) begin failures++; $display("FAIL empty_sw_ack got=%b exp=0", ack_seen); end
    checks++; if (rdy_low !== 1'b0) begin failures++; $display("FAIL empty_in_ready_low got=%b exp=0", rdy_low); end
    write_row(vec(16'd1, 16'd2));
    checks++; if (w_ready !== 1'b1) begin failures++; $display("FAIL loading_w_ready got=%b exp=1", w_ready); end
    write_row(vec(16'd3, 16'd4));
    checks++; if (w_ready !== 1'b0) begin failures++; $display("FAIL full_w_ready got=%b exp=0", w_ready); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL full_in_ready got=%b exp=1", in_ready); end
    switch_weights(acked, waited);
    checks++; if (acked !== 1'b1 || waited != 0) begin failures++; $display("FAIL basic_switch got=%b/%0d exp=1/0", acked, waited); end
    set_cols(2'd2);
    send_vec(vec(16'd5, 16'd6), got, lat);
    checks++; if (lat != 2 * N) begin failures++; $display("FAIL basic_latency got=%0d exp=%0d", lat, 2 * N); end
    checks++; if (got !== res(16'd23, 16'd34)) begin failures++; $display("FAIL basic_result got=%h exp=%h", got, res(16'd23, 16'd34)); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_single_pulse got=%b exp=0", out_valid); end
  endtask

  task automatic test_stream();
    logic exp_v;
    logic [N*PW-1:0] exp_d;
    for (int j = 0; j < 18; j++) begin
      exp_v = (j >= 5 && j <= 12);
      checks++; if (out_valid !== exp_v) begin failures++; $display("FAIL stream_valid_%0d got=%b exp=%b", j, out_valid, exp_v); end
      if (exp_v) begin
        exp_d = res(16'(j - 5 + 3), 16'(2 * (j - 5) + 4));
        checks++; if (out_data !== exp_d) begin failures++; $display("FAIL stream_data_%0d got=%h exp=%h", j - 5, out_data, exp_d); end
      end
      in_valid = (j < 8);
      in_data  = vec(16'(j), 16'd1);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_switch_load();
    logic [N*PW-1:0] exp_q[$];
    logic [N*PW-1:0] e, got;
    int ack_at, lat;
    ack_at = -1;
    for (int j = 0; j < 40 && ack_at < 0; j++) begin
      if (out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL swload_extra_out got=%h exp=none", out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e) begin failures++; $display("FAIL swload_old_result got=%h exp=%h", out_data, e); end
        end
      end
      if (sw_ack) begin
        ack_at = j;
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL swload_inflight got=%0d exp=0", exp_q.size()); end
      end else begin
        w_valid  = (j < 2);
        w_data   = (j == 0) ? vec(16'd1, 16'd0) : vec(16'd0, 16'd1);
        sw_req   = (j >= 2);
        in_valid = 1'b1;
        in_data  = vec(16'(10 + j), 16'd1);
        #1;
        checks++; if (in_ready !== (j < 2)) begin failures++; $display("FAIL swload_in_ready_%0d got=%b exp=%b", j, in_ready, j < 2); end
        if (j < 2) exp_q.push_back(res(16'(13 + j), 16'(2 * (10 + j) + 4)));
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
    sw_req   = 1'b0;
    // Last old vector accepted at edge 1 emits at edge 5; switch follows at edge 6.
    checks++; if (ack_at != 7) begin failures++; $display("FAIL swload_ack_cycle got=%0d exp=7", ack_at); end
    @(negedge clk);
    checks++; if (sw_ack !== 1'b0) begin failures++; $display("FAIL swload_ack_pulse got=%b exp=0", sw_ack); end
    send_vec(vec(16'd7, 16'hFFFE), got, lat);
    checks++; if (lat != 2 * N || got !== res(16'd7, 16'hFFFE)) begin failures++; $display("FAIL swload_new_result got=%h/%0d exp=%h/%0d", got, lat, res(16'd7, 16'hFFFE), 2 * N); end
    @(negedge clk);
  endtask

  task automatic test_mask();
    logic [N*PW-1:0] got;
    int lat, waited;
    logic acked;
    write_row(vec(16'd1, 16'd2));
    write_row(vec(16'd3, 16'd4));
    switch_weights(acked, waited);
    checks++; if (acked !== 1'b1) begin failures++; $display("FAIL mask_switch got=%b exp=1", acked); end
    set_cols(2'd1);
    send_vec(vec(16'd5, 16'd6), got, lat);
    checks++; if (lat != 2 * N || got !== res(16'd23, 16'd0)) begin failures++; $display("FAIL mask_one_col got=%h exp=%h", got, res(16'd23, 16'd0)); end
    @(negedge clk);
    set_cols(2'd3);
    send_vec(vec(16'd5, 16'd6), got, lat);
    checks++; if (lat != 2 * N || got !== res(16'd23, 16'd34)) begin failures++; $display("FAIL mask_saturate got=%h exp=%h", got, res(16'd23, 16'd34)); end
    @(negedge clk);
  endtask

  task automatic test_wrap();
    logic [N*PW-1:0] got;
    int lat, waited;
    logic acked;
    write_row(vec(16'h7FFF, 16'h7FFF));
    write_row(vec(16'h7FFF, 16'h7FFF));
    switch_weights(acked, waited);
    checks++; if (acked !== 1'b1) begin failures++; $display("FAIL wrap_switch got=%b exp=1", acked); end
    send_vec(vec(16'h7FFF, 16'h7FFF), got, lat);
    checks++; if (lat != 2 * N || got !== res(16'h0002, 16'h0002)) begin failures++; $display("FAIL wrap_result got=%h exp=%h", got, res(16'h0002, 16'h0002)); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [N*PW-1:0] got;
    int lat;
    logic seen;
    in_valid = 1'b1; in_data = vec(16'd1, 16'd1);
    w_valid = 1'b1; w_data = vec(16'd5, 16'd5);
    @(negedge clk);
    w_valid = 1'b0; in_data = vec(16'd2, 16'd2);
    @(negedge clk);
    in_data = vec(16'd3, 16'd3);
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checks++; if (w_ready !== 1'b1) begin failures++; $display("FAIL rstmid_w_ready got=%b exp=1", w_ready); end
    seen = 1'b0;
    for (int j = 0; j < 8; j++) begin
      if (out_valid) seen = 1'b1;
      @(negedge clk);
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rstmid_stale_out got=%b exp=0", seen); end
    // The row counter restarted, so one more row must leave the loader not full.
    write_row(vec(16'd9, 16'd9));
    checks++; if (w_ready !== 1'b1) begin failures++; $display("FAIL rstmid_row_count got=%b exp=1", w_ready); end
    set_cols(2'd2);
    send_vec(vec(16'd5, 16'd6), got, lat);
    checks++; if (lat != 2 * N || got !== '0) begin failures++; $display("FAIL rstmid_zero_wact got=%h/%0d exp=0/%0d", got, lat, 2 * N); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stream();
    test_switch_load();
    test_mask();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/systolic_nxn.md
SYSTOLIC_NXN -- requirements
Module: systolic_nxn

Interface
REQ-001 SHALL have parameter N, default 4, rows = columns of the PE grid (N >= 2).
REQ-002 SHALL have parameter DATA_W, default 16, width of the signed input and weight elements.
REQ-003 SHALL have parameter PSUM_W, default 32, width of the signed partial sums and results.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-low reset (0 = reset, sampled on the rising edge of clk).
REQ-006 in_data  input  N*DATA_W  input vector; element r at bits [r*DATA_W +: DATA_W].
REQ-007 in_valid / in_ready  input / output  1 each  input vector handshake.
REQ-008 w_data  input  N*DATA_W  one weight row; element c at bits [c*DATA_W +: DATA_W].
REQ-009 w_valid / w_ready  input / output  1 each  weight-row handshake.
REQ-010 sw_req  input  1  request to copy the shadow weights into the active weights.
REQ-011 sw_ack  output  1  one-cycle pulse when the copy occurs.
REQ-012 col_size  input  $clog2(N+1)  number of enabled columns.
REQ-013 col_size_valid  input  1  load strobe for col_size.
REQ-014 out_data  output  N*PSUM_W  result vector; column c at bits [c*PSUM_W +: PSUM_W].
REQ-015 out_valid  output  1  out_data is valid; single-cycle pulse per result with no backpressure.

Function
REQ-016 An input vector SHALL be accepted on an edge where in_valid && in_ready.
REQ-017 For a vector accepted at edge t, the aligned result SHALL appear with out_valid=1 exactly at edge t+2N, with all columns in the same cycle.
- Row r is skewed by r cycles internally.
- Column c is deskewed by N-1-c cycles internally.
REQ-018 Result: out[c] = sum over r of in[r]*Wact[r][c] for enabled c, and 0 for disabled c.
- Arithmetic is signed.
- Products are sign-extended to PSUM_W.
- The sum wraps modulo 2^PSUM_W; there is no saturation.
REQ-019 Back-to-back inputs SHALL be accepted every cycle, giving one result per cycle.
REQ-020 Shadow-weight FSM SHALL use the states EMPTY, LOADING and FULL, with a row counter k in 0..N-1.
REQ-021 w_ready SHALL be 1 in EMPTY and LOADING, and 0 in FULL.
REQ-022 Each accepted weight row SHALL be written to Wsh[k][*], and k SHALL then increment.
- EMPTY goes to LOADING on the first accepted row.
- The transition to FULL occurs when row N-1 is accepted (k wraps to 0).
- For N rows loaded back-to-back this is a total of N cycles.
REQ-023 Weight loading SHALL be concurrent with computation and SHALL NOT disturb Wact.
REQ-024 An in-flight counter SHALL count accepted vectors whose result has not yet emitted.
- Simultaneous accept and emit leaves the counter unchanged.
REQ-025 in_ready SHALL be 0 while state == FULL and sw_req == 1; otherwise in_ready SHALL be 1.
REQ-026 A switch SHALL be performed on an edge where state == FULL, sw_req == 1 and the in-flight count == 0.
- At that edge, all N*N Wact entries are loaded from Wsh.
- sw_ack pulses for one cycle.
- The FSM returns to EMPTY.
REQ-027 sw_req in EMPTY or LOADING SHALL be ignored, with no sw_ack, and SHALL NOT block inputs.
REQ-028 A vector accepted after sw_ack SHALL use the new Wact.
- Every vector accepted before the switch has completed with the old Wact.
REQ-029 On col_size_valid, the enable mask SHALL become (1<<min(col_size,N))-1 from the next cycle.
- The mask is applied at the output stage.
- col_size = 0 disables all columns.
REQ-030 The enable mask SHALL gate out_data only; it SHALL NOT gate out_valid.
REQ-031 Simultaneous weight-row accept and switch SHALL be impossible, because w_ready == 0 in FULL.

Reset
REQ-032 While rst == 0 at an edge, the block SHALL clear the following:
- all pipeline, skew and deskew registers;
- Wsh and Wact;
- the in-flight counter and k;
- the enable mask (0, all columns disabled).
REQ-033 While rst == 0, the FSM SHALL be in EMPTY.
REQ-034 While rst == 0, outputs SHALL be: out_data = 0, out_valid = 0, sw_ack = 0, w_ready = 1, in_ready = 1.
REQ-035 A reset during computation or weight loading SHALL discard all in-flight results and partial rows.
- No out_valid is produced for vectors accepted before the reset.

Verification
REQ-036 Bench SHALL run with N=2 and check basic compute.
- Stimulus: load rows [1,2] and [3,4]; sw_req; col_size=2; input [5,6] at t.
- Required: out_valid at t+4 with out = [23,34].
REQ-037 Bench SHALL check streaming.
- Stimulus: 8 back-to-back vectors [i,1] with the weights above.
- Required: 8 consecutive out_valid pulses, the i-th equal to [i+3, 2i+4].
REQ-038 Bench SHALL check a switch under load.
- Stimulus: shadow = identity loaded while streaming; sw_req held.
- Required:
  - in_ready drops;
  - sw_ack occurs only once in-flight = 0;
  - the next input [7,-2] gives [7,-2].
REQ-039 Bench SHALL check column masking.
- Stimulus: col_size=1, input [5,6].
- Required: [23,0].
- Stimulus: col_size=3 (saturates to N=2).
- Required: both columns enabled.
REQ-040 Bench SHALL check wraparound.
- Stimulus: N=2, PSUM_W=16, weights all 0x7FFF, input [0x7FFF,0x7FFF].
- Required: out[c] = 2*0x3FFF0001 mod 2^16 = 0x0002.
REQ-041 Bench SHALL check reset mid-operation.
- Stimulus: rst=0 for one edge after 3 accepted vectors and 1 weight row.
- Required:
  - no out_valid follows;
  - the FSM is EMPTY and w_ready = 1;
  - the next result uses Wact = 0, giving [0,0].
